// File: rtl/poker_frame_parser.sv
// Frame parser for the UART command stream: SOF 0xAA, CMD, N card bytes, XOR checksum.
// Frames are validated in full before hand/play/fpga-first results are released.
module poker_frame_parser #(
    parameter int HAND_SIZE   = 17,
    parameter int MAX_PLAY    = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [7:0]              in_data,
    input  logic                    in_flag,
    output logic                    hand_valid,
    output logic [HAND_SIZE*8-1:0]  hand_data,
    output logic                    play_valid,
    output logic [MAX_PLAY*8-1:0]   play_data,
    output logic [5:0]              play_cnt,
    output logic                    fpga_first,
    output logic                    err,
    output logic [1:0]              err_code,
    output logic [15:0]             frame_cnt,
    output logic [7:0]              err_cnt
);

    localparam int SH = (HAND_SIZE > MAX_PLAY) ? HAND_SIZE : MAX_PLAY;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] T_TERM = TW'(TIMEOUT_CYC - 1);
    localparam logic [5:0] HAND_N = 6'(HAND_SIZE);
    localparam logic [5:0] PLAY_N = 6'(MAX_PLAY);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_CSUM} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              type_q, type_d;
    logic [5:0]              n_q, n_d;
    logic [5:0]              idx_q, idx_d;
    logic [7:0]              csum_q, csum_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic [SH*8-1:0]         shadow_q, shadow_d;
    logic                    hand_valid_q, hand_valid_d;
    logic [HAND_SIZE*8-1:0]  hand_data_q, hand_data_d;
    logic                    play_valid_q, play_valid_d;
    logic [MAX_PLAY*8-1:0]   play_data_q, play_data_d;
    logic [5:0]              play_cnt_q, play_cnt_d;
    logic                    fpga_first_q, fpga_first_d;
    logic                    err_q, err_d;
    logic [1:0]              err_code_q, err_code_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic [7:0]              err_cnt_q, err_cnt_d;

    logic                    cmd_legal;
    logic                    drop;
    logic [1:0]              drop_code;

    always_comb begin
        cmd_legal = 1'b0;
        case (in_data[7:6])
            2'b00:   cmd_legal = (in_data[5:0] == HAND_N);
            2'b01:   cmd_legal = (in_data[5:0] != 6'd0) && (in_data[5:0] <= PLAY_N);
            2'b10:   cmd_legal = (in_data[5:0] == 6'd0);
            default: cmd_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        n_d          = n_q;
        idx_d        = idx_q;
        csum_d       = csum_q;
        tcnt_d       = tcnt_q;
        shadow_d     = shadow_q;
        hand_valid_d = 1'b0;
        hand_data_d  = hand_data_q;
        play_valid_d = 1'b0;
        play_data_d  = play_data_q;
        play_cnt_d   = play_cnt_q;
        fpga_first_d = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        frame_cnt_d  = frame_cnt_q;
        err_cnt_d    = err_cnt_q;
        drop         = 1'b0;
        drop_code    = 2'd0;

        if (state_q == S_IDLE) begin
            tcnt_d = '0;
            if (in_flag && in_data == 8'hAA) begin
                state_d = S_CMD;
            end
        end else if (in_flag) begin
            // Any byte inside a frame restarts the inter-byte timer, even on the terminal count.
            tcnt_d = '0;
            case (state_q)
                S_CMD: begin
                    type_d = in_data[7:6];
                    n_d    = in_data[5:0];
                    csum_d = in_data;
                    idx_d  = 6'd0;
                    if (!cmd_legal) begin
                        drop      = 1'b1;
                        drop_code = 2'd1;
                    end else if (in_data[5:0] == 6'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    shadow_d[int'(idx_q)*8 +: 8] = in_data;
                    csum_d = csum_q ^ in_data;
                    idx_d  = idx_q + 6'd1;
                    if (idx_q + 6'd1 == n_q) begin
                        state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    state_d = S_IDLE;
                    if (in_data == csum_q) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        case (type_q)
                            2'b00: begin
                                hand_data_d  = shadow_q[HAND_SIZE*8-1:0];
                                hand_valid_d = 1'b1;
                            end
                            2'b01: begin
                                for (int i = 0; i < MAX_PLAY; i++) begin
                                    play_data_d[i*8 +: 8] = (i < int'(n_q)) ? shadow_q[i*8 +: 8] : 8'h00;
                                end
                                play_cnt_d   = n_q;
                                play_valid_d = 1'b1;
                            end
                            default: fpga_first_d = 1'b1;
                        endcase
                    end else begin
                        drop      = 1'b1;
                        drop_code = 2'd2;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (tcnt_q == T_TERM) begin
            drop      = 1'b1;
            drop_code = 2'd3;
        end else begin
            tcnt_d = tcnt_q + TW'(1);
        end

        if (drop) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            err_code_d = drop_code;
            err_cnt_d  = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            type_q       <= 2'd0;
            n_q          <= 6'd0;
            idx_q        <= 6'd0;
            csum_q       <= 8'd0;
            tcnt_q       <= '0;
            shadow_q     <= '0;
            hand_valid_q <= 1'b0;
            hand_data_q  <= '0;
            play_valid_q <= 1'b0;
            play_data_q  <= '0;
            play_cnt_q   <= 6'd0;
            fpga_first_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'd0;
            frame_cnt_q  <= 16'd0;
            err_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            csum_q       <= csum_d;
            tcnt_q       <= tcnt_d;
            shadow_q     <= shadow_d;
            hand_valid_q <= hand_valid_d;
            hand_data_q  <= hand_data_d;
            play_valid_q <= play_valid_d;
            play_data_q  <= play_data_d;
            play_cnt_q   <= play_cnt_d;
            fpga_first_q <= fpga_first_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign hand_valid = hand_valid_q;
    assign hand_data  = hand_data_q;
    assign play_valid = play_valid_q;
    assign play_data  = play_data_q;
    assign play_cnt   = play_cnt_q;
    assign fpga_first = fpga_first_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_poker_frame_parser.sv
// Scoreboard bench for poker_frame_parser: frame-level reference model predicts each
// result pulse, its cycle and the held output values; a negedge monitor compares.
module tb_poker_frame_parser;

    localparam int HS = 17;
    localparam int MP = 4;
    localparam int TO = 100;

    logic              clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic [7:0]        in_data = 8'h00;
    logic              in_flag = 1'b0;
    logic              hand_valid;
    logic [HS*8-1:0]   hand_data;
    logic              play_valid;
    logic [MP*8-1:0]   play_data;
    logic [5:0]        play_cnt;
    logic              fpga_first;
    logic              err;
    logic [1:0]        err_code;
    logic [15:0]       frame_cnt;
    logic [7:0]        err_cnt;

    poker_frame_parser #(.HAND_SIZE(HS), .MAX_PLAY(MP), .TIMEOUT_CYC(TO)) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .in_data(in_data), .in_flag(in_flag),
        .hand_valid(hand_valid), .hand_data(hand_data),
        .play_valid(play_valid), .play_data(play_data), .play_cnt(play_cnt),
        .fpga_first(fpga_first), .err(err), .err_code(err_code),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              kind;
        int              at;
        logic [HS*8-1:0] hand;
        logic [MP*8-1:0] play;
        logic [5:0]      pcnt;
        logic [1:0]      ecode;
        logic [15:0]     fcnt;
        logic [7:0]      ecnt;
    } exp_t;

    exp_t            exp_q[$];
    int              total = 0;
    int              bad = 0;
    int              last_cyc = 0;
    logic [7:0]      cards [64];

    logic [HS*8-1:0] m_hand = '0;
    logic [MP*8-1:0] m_play = '0;
    logic [5:0]      m_pcnt = '0;
    logic [1:0]      m_ecode = '0;
    logic [15:0]     m_fcnt = '0;
    logic [7:0]      m_ecnt = '0;

    task automatic check_output(input string name, input logic [HS*8-1:0] act, input logic [HS*8-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit frame_legal(input logic [7:0] cmd);
        int n = int'(cmd[5:0]);
        case (cmd[7:6])
            2'b00:   return n == HS;
            2'b01:   return n >= 1 && n <= MP;
            2'b10:   return n == 0;
            default: return 0;
        endcase
    endfunction

    function automatic int pick_gap(input int mode);
        if (mode == 0) return 0;
        if (mode == 2) return TO - 1;
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(50, TO - 1));
        return int'($urandom_range(0, 3));
    endfunction

    function automatic exp_t snapshot(input int kind, input int at);
        exp_t e;
        e.kind = kind; e.at = at; e.hand = m_hand; e.play = m_play; e.pcnt = m_pcnt;
        e.ecode = m_ecode; e.fcnt = m_fcnt; e.ecnt = m_ecnt;
        return e;
    endfunction

    task automatic model_err(input logic [1:0] code, input int at);
        m_ecode = code;
        if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
        exp_q.push_back(snapshot(3, at));
    endtask

    task automatic model_commit(input logic [7:0] cmd);
        int n = int'(cmd[5:0]);
        int kind = int'(cmd[7:6]);
        if (kind == 0) begin
            for (int i = 0; i < HS; i++) m_hand[i*8 +: 8] = cards[i];
        end else if (kind == 1) begin
            m_play = '0;
            for (int i = 0; i < n; i++) m_play[i*8 +: 8] = cards[i];
            m_pcnt = cmd[5:0];
        end
        m_fcnt = m_fcnt + 16'd1;
        exp_q.push_back(snapshot(kind, last_cyc));
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        #1;
        in_data = b;
        in_flag = 1'b1;
        @(posedge clk);
        #1;
        in_flag = 1'b0;
        last_cyc = cyc;
    endtask

    // Sends one whole frame; the model decides legality and outcome from the frame contents.
    task automatic apply_stimulus(input logic [7:0] cmd, input logic [7:0] csum_flip, input int gap_mode);
        logic [7:0] x;
        int n = int'(cmd[5:0]);
        send_byte(8'hAA, pick_gap(gap_mode));
        send_byte(cmd, pick_gap(gap_mode));
        if (!frame_legal(cmd)) begin
            model_err(2'd1, last_cyc);
            return;
        end
        x = cmd;
        for (int i = 0; i < n; i++) begin
            send_byte(cards[i], pick_gap(gap_mode));
            x = x ^ cards[i];
        end
        send_byte(x ^ csum_flip, pick_gap(gap_mode));
        if (csum_flip != 8'h00) model_err(2'd2, last_cyc);
        else model_commit(cmd);
    endtask

    task automatic check_reset_outputs();
        check_output("rst_hand_valid", HS*8'(hand_valid), '0);
        check_output("rst_hand_data", hand_data, '0);
        check_output("rst_play_valid", HS*8'(play_valid), '0);
        check_output("rst_play_data", HS*8'(play_data), '0);
        check_output("rst_play_cnt", HS*8'(play_cnt), '0);
        check_output("rst_fpga_first", HS*8'(fpga_first), '0);
        check_output("rst_err", HS*8'(err), '0);
        check_output("rst_err_code", HS*8'(err_code), '0);
        check_output("rst_frame_cnt", HS*8'(frame_cnt), '0);
        check_output("rst_err_cnt", HS*8'(err_cnt), '0);
    endtask

    always @(negedge clk) begin
        int   npulse;
        int   okind;
        exp_t e;
        npulse = int'(hand_valid) + int'(play_valid) + int'(fpga_first) + int'(err);
        if (npulse != 0) begin
            okind = hand_valid ? 0 : play_valid ? 1 : fpga_first ? 2 : 3;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_pulse: got kind %0d at cycle %0d, expected none", okind, cyc);
            end else begin
                e = exp_q.pop_front();
                check_output("pulse_onehot", HS*8'(npulse), HS*8'(1));
                check_output("pulse_kind", HS*8'(okind), HS*8'(e.kind));
                check_output("pulse_cycle", HS*8'(cyc), HS*8'(e.at));
                check_output("hand_data", hand_data, e.hand);
                check_output("play_data", HS*8'(play_data), HS*8'(e.play));
                check_output("play_cnt", HS*8'(play_cnt), HS*8'(e.pcnt));
                check_output("err_code", HS*8'(err_code), HS*8'(e.ecode));
                check_output("frame_cnt", HS*8'(frame_cnt), HS*8'(e.fcnt));
                check_output("err_cnt", HS*8'(err_cnt), HS*8'(e.ecnt));
            end
        end
    end

    initial begin
        logic [7:0] cmd;
        int         r;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        sys_rst = 1'b0;

        $display("[TB] directed play frame");
        cards[0] = 8'h3A; cards[1] = 8'h3B;
        apply_stimulus(8'h42, 8'h00, 0);

        $display("[TB] fpga-first with leading junk");
        send_byte(8'h55, 0);
        apply_stimulus(8'h80, 8'h00, 0);

        $display("[TB] full hand");
        for (int i = 0; i < HS; i++) cards[i] = 8'(i + 1);
        apply_stimulus(8'h11, 8'h00, 0);

        $display("[TB] bad checksum then good frame");
        cards[0] = 8'h3A;
        apply_stimulus(8'h41, 8'h7B, 0);
        apply_stimulus(8'h41, 8'h00, 0);

        $display("[TB] bad counts");
        apply_stimulus(8'h45, 8'h00, 0);
        apply_stimulus(8'h10, 8'h00, 0);

        $display("[TB] timeout");
        send_byte(8'hAA, 0);
        send_byte(8'h42, 0);
        send_byte(8'h3A, 0);
        model_err(2'd3, last_cyc + TO);
        repeat (TO + 5) @(posedge clk);
        #1;

        $display("[TB] strobe on terminal count");
        cards[0] = 8'h3A; cards[1] = 8'h3B;
        apply_stimulus(8'h42, 8'h00, 2);

        $display("[TB] reset mid-frame");
        send_byte(8'hAA, 0);
        send_byte(8'h42, 0);
        send_byte(8'h3A, 0);
        sys_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        sys_rst = 1'b0;
        m_hand = '0; m_play = '0; m_pcnt = '0; m_ecode = '0; m_fcnt = '0; m_ecnt = '0;
        apply_stimulus(8'h42, 8'h00, 0);

        $display("[TB] random frames");
        for (int f = 0; f < 60; f++) begin
            for (int i = 0; i < 64; i++) cards[i] = 8'($urandom);
            r = int'($urandom_range(0, 3));
            case (r)
                0:       cmd = 8'(HS);
                1:       cmd = 8'h40 | 8'($urandom_range(1, MP));
                2:       cmd = 8'h80;
                default: cmd = 8'($urandom);
            endcase
            if ($urandom_range(0, 4) == 0) begin
                r = int'($urandom_range(0, 255));
                send_byte((r == 8'hAA) ? 8'h00 : 8'(r), int'($urandom_range(0, 3)));
            end
            apply_stimulus(cmd, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 1);
        end

        repeat (10) @(posedge clk);
        #1;
        check_output("scoreboard_empty", HS*8'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
